fetch_decode_buffer: RTL
========================

// Module: fetch_decode_buffer
// PURPOSE
//  - Receiving end of the fetch stage output: accepts {instruction, control bundle, pc_seq} beats and delivers them to decode.
//  - 2-entry skid buffer forming the IF/ID pipeline register, with valid/ready handshake on both sides.
//  - Supports flush on branch/jump redirect and substitutes the NOP (ori $zero,$zero,0) whenever no beat is valid.
//  - Its ready output is the fetch stage's PC-enable back-pressure.
// PARAMETERS
//  - IW        32            instruction width
//  - BW        26            control bundle width
//  - NOP_INSTR 32'h3400_0000 instruction presented when invalid or flushed
//  - CNT_W     16            width of the saturating stall counter
// PORTS
//  - clk              in   1      rising-edge clock
//  - reset            in   1      asynchronous, active-low reset
//  - instruction_in   in   IW     instruction from fetch
//  - bundle_in        in   BW     decoded control bundle from fetch
//  - pc_seq_in        in   32     PC+4 of the instruction
//  - fetch_valid_in   in   1      fetch beat valid
//  - fetch_ready_out  out  1      buffer can accept; drives fetch PC enable
//  - instruction_out  out  IW     head instruction, NOP_INSTR when !valid_out
//  - bundle_out       out  BW     head bundle, all-zero when !valid_out
//  - pc_seq_out       out  32     head PC+4; holds last value when !valid_out
//  - valid_out        out  1      head entry valid
//  - decode_ready_in  in   1      decode accepts head (low = hazard stall)
//  - flush_in         in   1      redirect; discard all buffered and incoming beats
//  - occupancy_out    out  2      entries held: 0, 1 or 2
//  - stall_count_out  out  CNT_W  cycles with valid_out=1 and decode_ready_in=0, saturating
// BEHAVIOUR
//  - Reset (reset=0, async): both entries invalid; instruction_out=NOP_INSTR; bundle_out=0; pc_seq_out=0;
//    valid_out=0; fetch_ready_out=1; occupancy_out=0; stall_count_out=0. Leaving reset is synchronous to clk.
//  - Handshakes: accept = fetch_valid_in & fetch_ready_out; consume = valid_out & decode_ready_in.
//  - fetch_ready_out = !skid_valid, registered (no combinational path from decode_ready_in).
//  - States are derived from {head_valid, skid_valid}:
//    - EMPTY: accept -> ONE (head <= in).
//    - ONE:
//      - accept & consume -> ONE (head <= in).
//      - accept only -> FULL (skid <= in).
//      - consume only -> EMPTY.
//    - FULL (fetch_ready_out=0): consume -> ONE (head <= skid); otherwise hold.
//  - Latency: an accepted beat reaches valid_out one cycle later when the buffer is empty. Order is strictly FIFO.
//  - No beat is lost or duplicated. A held head keeps instruction/bundle/pc_seq stable until consumed.
//  - flush_in has highest priority, synchronous:
//    - the next cycle has both entries invalid, occupancy 0, fetch_ready_out=1 and NOP outputs;
//    - a beat accepted in the flush cycle is discarded;
//    - a head consumed in the flush cycle counts as delivered;
//    - flush in EMPTY is harmless.
//  - stall_count_out increments by 1 per cycle with valid_out & !decode_ready_in.
//    It saturates at 2^CNT_W-1, is unaffected by flush, and is cleared only by reset.
//  - occupancy_out = head_valid + skid_valid, registered.
// STRUCTURE
//  - Shared package pipe_pkg: NOP_INSTR, BUNDLE_W, bundle bit-index constants (regfile_we=0, data_mem_we=3, ...).
//    The all-zero "nop bundle" is defined in pipe_pkg as well.
//  - Single module. The payload registers are two instances of one natural sub-module, pipe_entry
//    ({valid, instr, bundle, pc_seq} register with load/clear). The stall counter is inline.
// TESTING
//  - Reset mid-stream with occupancy 2 -> next cycle: valid_out=0, instruction_out=32'h3400_0000, bundle_out=0,
//    fetch_ready_out=1.
//  - Stream 0x20080001..0x20080004 with decode_ready_in=1 -> each appears 1 cycle later, in order, occupancy_out=1,
//    no bubbles.
//  - Hold decode_ready_in=0 for 5 cycles while fetch is valid:
//    - occupancy 1->2 and fetch_ready_out=0 after 2 accepts;
//    - stall_count_out=5;
//    - on release, the head then skid drain in order.
//  - FULL with flush_in=1 while fetch_valid_in=1 -> next cycle valid_out=0 and occupancy 0; the flush-cycle beat never appears.
//  - ONE, accept and consume in the same cycle -> new beat at head, occupancy stays 1, consumed beat seen exactly once.
//  - CNT_W=3, stall for 10 cycles -> stall_count_out saturates at 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared pipeline definitions for the IF/ID boundary: instruction and
//   control-bundle widths, the NOP encoding driven into decode when no beat
//   is valid, and the bit positions of the individual control signals inside
//   the fetch-stage control bundle.
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Datapath widths
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned BUNDLE_W = 26;
    localparam int unsigned PC_W     = 32;

    // ori $zero,$zero,0 : architecturally a no-op, safe to feed decode
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h3400_0000;

    // Control bundle bit positions
    localparam int unsigned BIT_REGFILE_WE   = 0;
    localparam int unsigned BIT_MEM_TO_REG   = 1;
    localparam int unsigned BIT_DATA_MEM_RE  = 2;
    localparam int unsigned BIT_DATA_MEM_WE  = 3;
    localparam int unsigned BIT_ALU_SRC      = 4;
    localparam int unsigned BIT_REG_DST      = 5;
    localparam int unsigned BIT_BRANCH       = 6;
    localparam int unsigned BIT_JUMP         = 7;
    localparam int unsigned BIT_ALU_OP_LSB   = 8;   // 4-bit ALU opcode field
    localparam int unsigned BIT_ALU_OP_MSB   = 11;

    // A bundle with every control asserted low does nothing in later stages
    localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = '0;

    // Number of held entries from the two valid flags; the skid entry is
    // only ever valid while the head entry is valid.
    function automatic logic [1:0] entry_count(input logic head_v, input logic skid_v);
        return {head_v & skid_v, head_v ^ skid_v};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
//   One pipeline register slot: {valid, instruction, bundle, pc_seq}.
//   load_en captures the payload and sets valid; clear_en drops valid only,
//   so the payload (in particular pc_seq) keeps its last value.
//   clear_en wins if both are asserted.
//
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   load_en   in   capture payload, set valid
//   clear_en  in   drop valid
//   instr_d   in   IW  instruction to capture
//   bundle_d  in   BW  control bundle to capture
//   pc_seq_d  in   32  PC+4 to capture
//   valid_q   out  slot holds a beat
//   instr_q   out  IW  stored instruction
//   bundle_q  out  BW  stored bundle
//   pc_seq_q  out  32  stored PC+4
// ---------------------------------------------------------------------------
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned IW = INSTR_W,
    parameter int unsigned BW = BUNDLE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic          clear_en,
    input  logic [IW-1:0] instr_d,
    input  logic [BW-1:0] bundle_d,
    input  logic [31:0]   pc_seq_d,
    output logic          valid_q,
    output logic [IW-1:0] instr_q,
    output logic [BW-1:0] bundle_q,
    output logic [31:0]   pc_seq_q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else if (clear_en) begin
            valid_q <= 1'b0;
        end else if (load_en) begin
            valid_q <= 1'b1;
        end
    end

    // Payload has no clear path: the head pc_seq must survive a flush or drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q  <= '0;
            bundle_q <= '0;
            pc_seq_q <= '0;
        end else if (load_en && !clear_en) begin
            instr_q  <= instr_d;
            bundle_q <= bundle_d;
            pc_seq_q <= pc_seq_d;
        end
    end

endmodule

// File: rtl/fetch_decode_buffer.sv
// ---------------------------------------------------------------------------
// fetch_decode_buffer
//   IF/ID pipeline register built as a 2-entry skid buffer. Beats of
//   {instruction, control bundle, pc_seq} from fetch are handed to decode in
//   strict FIFO order with valid/ready on both sides. A redirect flush drops
//   everything held plus the beat offered in the same cycle. While no beat is
//   valid, decode sees NOP_INSTR and an all-zero bundle.
//
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   instruction_in   in   IW     instruction from fetch
//   bundle_in        in   BW     control bundle from fetch
//   pc_seq_in        in   32     PC+4 of the instruction
//   fetch_valid_in   in   fetch beat valid
//   fetch_ready_out  out  buffer can accept (fetch PC enable)
//   instruction_out  out  IW     head instruction or NOP_INSTR
//   bundle_out       out  BW     head bundle or zero
//   pc_seq_out       out  32     head PC+4, holds last value when empty
//   valid_out        out  head entry valid
//   decode_ready_in  in   decode accepts head
//   flush_in         in   discard buffered and incoming beats
//   occupancy_out    out  2      entries held
//   stall_count_out  out  CNT_W  saturating count of stalled-valid cycles
// ---------------------------------------------------------------------------
module fetch_decode_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned IW        = INSTR_W,
    parameter int unsigned BW        = BUNDLE_W,
    parameter logic [IW-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    instruction_in,
    input  logic [BW-1:0]    bundle_in,
    input  logic [31:0]      pc_seq_in,
    input  logic             fetch_valid_in,
    output logic             fetch_ready_out,
    output logic [IW-1:0]    instruction_out,
    output logic [BW-1:0]    bundle_out,
    output logic [31:0]      pc_seq_out,
    output logic             valid_out,
    input  logic             decode_ready_in,
    input  logic             flush_in,
    output logic [1:0]       occupancy_out,
    output logic [CNT_W-1:0] stall_count_out
);

    // Buffer state encoded as {head_valid, skid_valid}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic          head_valid;
    logic [IW-1:0] head_instr;
    logic [BW-1:0] head_bundle;
    logic [31:0]   head_pc_seq;

    logic          skid_valid;
    logic [IW-1:0] skid_instr;
    logic [BW-1:0] skid_bundle;
    logic [31:0]   skid_pc_seq;

    logic          head_load;
    logic          head_clear;
    logic          head_from_skid;
    logic          skid_load;
    logic          skid_clear;

    logic [IW-1:0] head_instr_d;
    logic [BW-1:0] head_bundle_d;
    logic [31:0]   head_pc_seq_d;

    logic [1:0]    state;
    logic          accept;
    logic          consume;

    logic [CNT_W-1:0] stall_cnt;

    assign state   = {head_valid, skid_valid};
    assign accept  = fetch_valid_in & fetch_ready_out;
    assign consume = head_valid & decode_ready_in;

    // -----------------------------------------------------------------------
    // Next-state / entry control
    // -----------------------------------------------------------------------
    always_comb begin
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (flush_in) begin
            // Incoming beat is dropped by simply not loading it.
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (consume) begin
                        head_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    // fetch_ready_out is low here, so accept cannot occur.
                    if (consume) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    // skid without head cannot be reached; recover to empty
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        head_instr_d  = instruction_in;
        head_bundle_d = bundle_in;
        head_pc_seq_d = pc_seq_in;
        if (head_from_skid) begin
            head_instr_d  = skid_instr;
            head_bundle_d = skid_bundle;
            head_pc_seq_d = skid_pc_seq;
        end
    end

    // -----------------------------------------------------------------------
    // Entry registers
    // -----------------------------------------------------------------------
    pipe_entry #(
        .IW (IW),
        .BW (BW)
    ) u_head (
        .clk      (clk),
        .reset    (reset),
        .load_en  (head_load),
        .clear_en (head_clear),
        .instr_d  (head_instr_d),
        .bundle_d (head_bundle_d),
        .pc_seq_d (head_pc_seq_d),
        .valid_q  (head_valid),
        .instr_q  (head_instr),
        .bundle_q (head_bundle),
        .pc_seq_q (head_pc_seq)
    );

    pipe_entry #(
        .IW (IW),
        .BW (BW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_en  (skid_load),
        .clear_en (skid_clear),
        .instr_d  (instruction_in),
        .bundle_d (bundle_in),
        .pc_seq_d (pc_seq_in),
        .valid_q  (skid_valid),
        .instr_q  (skid_instr),
        .bundle_q (skid_bundle),
        .pc_seq_q (skid_pc_seq)
    );

    // -----------------------------------------------------------------------
    // Saturating stall counter (flush does not touch it)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (head_valid && !decode_ready_in && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all status taken straight from flops, so ready and occupancy
    // have no combinational path from decode_ready_in.
    // -----------------------------------------------------------------------
    assign fetch_ready_out = ~skid_valid;
    assign occupancy_out   = entry_count(head_valid, skid_valid);
    assign valid_out       = head_valid;
    assign instruction_out = head_valid ? head_instr  : NOP_INSTR;
    assign bundle_out      = head_valid ? head_bundle : NOP_BUNDLE;
    assign pc_seq_out      = head_pc_seq;
    assign stall_count_out = stall_cnt;

endmodule
